// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: exception codes, fixed PCs and the
// per-cycle action taken by an inter-stage register.
package mips_pkg;

    localparam int EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;  // interrupts arrive on req, not as a code
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_REQ,
        ACT_FLUSH,
        ACT_STALL,
        ACT_LOAD
    } stage_act_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (inc && (r_count != '1))
            r_count <= r_count + W'(1);
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: PC, payload, valid, delay-slot flag and
// exception code, with req/flush/stall control and stall/bubble counters.
module pipe_stage_reg
    import mips_pkg::*;
#(
    parameter int              DATA_W         = 64,
    parameter int              PC_W           = 32,
    parameter int              EXC_W          = 5,
    parameter int              CNT_W          = 16,
    parameter logic [PC_W-1:0] RESET_PC       = 32'h0000_3000,
    parameter bit              BUBBLE_KEEP_PC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req,
    input  logic              valid_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              bd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [EXC_W-1:0]  exc_in,
    input  logic              exc_new,
    input  logic [EXC_W-1:0]  exc_new_code,
    output logic              valid_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              bd_out,
    output logic [DATA_W-1:0] data_out,
    output logic [EXC_W-1:0]  exc_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Earliest exception wins; a bubble never carries an exception.
    function automatic logic [EXC_W-1:0] exc_merge(
        input logic             valid,
        input logic [EXC_W-1:0] upstream,
        input logic             new_hit,
        input logic [EXC_W-1:0] new_code
    );
        if (!valid)
            return '0;
        else if (upstream != '0)
            return upstream;
        else if (new_hit)
            return new_code;
        else
            return '0;
    endfunction

    stage_act_e          w_act;
    logic                w_stall_inc;
    logic                w_bubble_inc;

    logic                r_valid;
    logic [PC_W-1:0]     r_pc;
    logic                r_bd;
    logic [DATA_W-1:0]   r_data;
    logic [EXC_W-1:0]    r_exc;

    always_comb begin
        w_act = ACT_LOAD;
        if (reset)      w_act = ACT_RESET;
        else if (req)   w_act = ACT_REQ;
        else if (flush) w_act = ACT_FLUSH;
        else if (stall) w_act = ACT_STALL;
    end

    assign w_stall_inc  = (w_act == ACT_STALL);
    assign w_bubble_inc = (w_act == ACT_FLUSH) || ((w_act == ACT_LOAD) && !valid_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_bd    <= 1'b0;
            r_data  <= '0;
            r_exc   <= '0;
        end else begin
            case (w_act)
                ACT_REQ: begin
                    r_valid <= 1'b0;
                    r_pc    <= PC_W'(HANDLER_PC);
                    r_bd    <= 1'b0;
                    r_data  <= '0;
                    r_exc   <= '0;
                end
                ACT_FLUSH: begin
                    // Keeping pc/bd in the bubble lets EPC be recovered downstream.
                    r_valid <= 1'b0;
                    r_pc    <= BUBBLE_KEEP_PC ? pc_in : '0;
                    r_bd    <= BUBBLE_KEEP_PC ? bd_in : 1'b0;
                    r_data  <= '0;
                    r_exc   <= '0;
                end
                ACT_LOAD: begin
                    r_valid <= valid_in;
                    r_pc    <= pc_in;
                    r_bd    <= bd_in;
                    r_data  <= data_in;
                    r_exc   <= exc_merge(valid_in, exc_in, exc_new, exc_new_code);
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );

    assign valid_out = r_valid;
    assign pc_out    = r_pc;
    assign bd_out    = r_bd;
    assign data_out  = r_data;
    assign exc_out   = r_exc;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default, no-keep-PC and 3-bit-counter
// instances share one stimulus stream.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, req, valid_in, bd_in, exc_new;
    logic [31:0] pc_in;
    logic [63:0] data_in;
    logic [4:0]  exc_in, exc_new_code;

    logic        v_a, bd_a, v_b, bd_b, v_c, bd_c;
    logic [31:0] pc_a, pc_b, pc_c;
    logic [63:0] d_a, d_b, d_c;
    logic [4:0]  e_a, e_b, e_c;
    logic [15:0] sc_a, bc_a, sc_b, bc_b;
    logic [2:0]  sc_c, bc_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
        .valid_in(valid_in), .pc_in(pc_in), .bd_in(bd_in), .data_in(data_in),
        .exc_in(exc_in), .exc_new(exc_new), .exc_new_code(exc_new_code),
        .valid_out(v_a), .pc_out(pc_a), .bd_out(bd_a), .data_out(d_a),
        .exc_out(e_a), .stall_cnt(sc_a), .bubble_cnt(bc_a)
    );

    pipe_stage_reg #(.BUBBLE_KEEP_PC(1'b0)) dut_nk (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
        .valid_in(valid_in), .pc_in(pc_in), .bd_in(bd_in), .data_in(data_in),
        .exc_in(exc_in), .exc_new(exc_new), .exc_new_code(exc_new_code),
        .valid_out(v_b), .pc_out(pc_b), .bd_out(bd_b), .data_out(d_b),
        .exc_out(e_b), .stall_cnt(sc_b), .bubble_cnt(bc_b)
    );

    pipe_stage_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
        .valid_in(valid_in), .pc_in(pc_in), .bd_in(bd_in), .data_in(data_in),
        .exc_in(exc_in), .exc_new(exc_new), .exc_new_code(exc_new_code),
        .valid_out(v_c), .pc_out(pc_c), .bd_out(bd_c), .data_out(d_c),
        .exc_out(e_c), .stall_cnt(sc_c), .bubble_cnt(bc_c)
    );

    typedef struct {
        logic        stall, flush, req, valid, bd, exc_new;
        logic [31:0] pc;
        logic [63:0] data;
        logic [4:0]  exc_in, code;
        logic        x_valid, x_bd;
        logic [31:0] x_pc;
        logic [63:0] x_data;
        logic [4:0]  x_exc;
        logic [15:0] x_sc, x_bc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; req = 0; valid_in = 1; bd_in = 0;
        exc_new = 0; pc_in = 32'h0; data_in = 64'h0; exc_in = 0; exc_new_code = 0;
    endtask

    initial begin
        //          st fl rq v  bd en pc            data   ein code | v  bd pc            data   exc sc bc
        vecs[0]  = '{0, 0, 0, 1, 0, 0, 32'h3004, 64'hA5, 0,  0,  1, 0, 32'h3004, 64'hA5, 0,  0, 0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 32'h3008, 64'h77, 0,  0,  1, 0, 32'h3004, 64'hA5, 0,  1, 0};
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 32'h3008, 64'h77, 0,  0,  1, 0, 32'h3004, 64'hA5, 0,  2, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 32'h3008, 64'h77, 0,  0,  1, 0, 32'h3004, 64'hA5, 0,  3, 0};
        vecs[4]  = '{1, 1, 0, 1, 1, 0, 32'h3010, 64'h99, 0,  0,  0, 1, 32'h3010, 64'h0,  0,  3, 1};
        vecs[5]  = '{0, 0, 0, 1, 0, 1, 32'h3014, 64'h11, 4,  12, 1, 0, 32'h3014, 64'h11, 4,  3, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, 1, 32'h3018, 64'h12, 0,  12, 1, 0, 32'h3018, 64'h12, 12, 3, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 32'h301C, 64'h22, 0,  12, 0, 0, 32'h301C, 64'h22, 0,  3, 2};
        vecs[8]  = '{0, 0, 0, 1, 0, 0, 32'h3020, 64'h33, 0,  0,  1, 0, 32'h3020, 64'h33, 0,  3, 2};
        vecs[9]  = '{1, 1, 1, 1, 1, 1, 32'h3024, 64'h55, 4,  12, 0, 0, 32'h4180, 64'h0,  0,  3, 2};
        vecs[10] = '{0, 0, 0, 1, 1, 0, 32'h3028, 64'h44, 10, 0,  1, 1, 32'h3028, 64'h44, 10, 3, 2};

        // Reset with arbitrary inputs applied
        idle();
        reset = 1; stall = 1; flush = 1; pc_in = 32'hDEAD; data_in = 64'hBEEF; exc_in = 5;
        step(); step();
        chk("rst_valid", 64'(v_a), 64'd0);
        chk("rst_pc", 64'(pc_a), 64'h3000);
        chk("rst_bd", 64'(bd_a), 64'd0);
        chk("rst_data", d_a, 64'd0);
        chk("rst_exc", 64'(e_a), 64'd0);
        chk("rst_stall_cnt", 64'(sc_a), 64'd0);
        chk("rst_bubble_cnt", 64'(bc_a), 64'd0);
        chk("rst_sat_cnt", 64'(sc_c), 64'd0);

        idle();
        for (int i = 0; i < 11; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush; req = vecs[i].req;
            valid_in = vecs[i].valid; bd_in = vecs[i].bd; exc_new = vecs[i].exc_new;
            pc_in = vecs[i].pc; data_in = vecs[i].data; exc_in = vecs[i].exc_in;
            exc_new_code = vecs[i].code;
            step();
            chk($sformatf("v%0d_valid", i), 64'(v_a), 64'(vecs[i].x_valid));
            chk($sformatf("v%0d_pc", i), 64'(pc_a), 64'(vecs[i].x_pc));
            chk($sformatf("v%0d_bd", i), 64'(bd_a), 64'(vecs[i].x_bd));
            chk($sformatf("v%0d_data", i), d_a, vecs[i].x_data);
            chk($sformatf("v%0d_exc", i), 64'(e_a), 64'(vecs[i].x_exc));
            chk($sformatf("v%0d_stall_cnt", i), 64'(sc_a), 64'(vecs[i].x_sc));
            chk($sformatf("v%0d_bubble_cnt", i), 64'(bc_a), 64'(vecs[i].x_bc));
        end

        // Flush bubble with and without PC retention
        idle();
        flush = 1; stall = 1; pc_in = 32'h3030; bd_in = 1; data_in = 64'h66;
        step();
        chk("keep_pc", 64'(pc_a), 64'h3030);
        chk("keep_bd", 64'(bd_a), 64'd1);
        chk("nokeep_pc", 64'(pc_b), 64'd0);
        chk("nokeep_bd", 64'(bd_b), 64'd0);
        chk("nokeep_valid", 64'(v_b), 64'd0);
        chk("nokeep_data", d_b, 64'd0);
        chk("flush_bubble_cnt", 64'(bc_a), 64'd3);
        chk("flush_stall_cnt", 64'(sc_a), 64'd3);

        // Reset mid-stall wins, then normal operation resumes
        idle();
        stall = 1; reset = 1; pc_in = 32'h3034;
        step();
        chk("rst_stall_pc", 64'(pc_a), 64'h3000);
        chk("rst_stall_cnt", 64'(sc_a), 64'd0);
        chk("rst_stall_bubble", 64'(bc_a), 64'd0);
        idle();
        pc_in = 32'h3040; data_in = 64'h88;
        step();
        chk("post_rst_pc", 64'(pc_a), 64'h3040);
        chk("post_rst_valid", 64'(v_a), 64'd1);

        // Saturation of a 3-bit stall counter
        idle();
        stall = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("sat_%0d", i), 64'(sc_c), 64'((i > 7) ? 7 : i));
        end
        chk("wide_stall_cnt", 64'(sc_a), 64'd10);
        chk("sat_hold_pc", 64'(pc_c), 64'h3040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
